// File: rtl/cpen391_pio_pkg.sv
// Shared definitions for the CPEN391 input PIO blocks.
// Contents:
//   - Avalon word addresses of the PIO register map
//   - EDGE_TYPE encodings for the capture edge select
//   - cnt_width(): width of a debounce counter that must hold the value DEBOUNCE
package cpen391_pio_pkg;

  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;

  localparam int unsigned EDGE_RISE = 0;
  localparam int unsigned EDGE_FALL = 1;
  localparam int unsigned EDGE_ANY  = 2;

  // The counter has to reach DEBOUNCE itself, so it needs clog2(DEBOUNCE+1) bits (minimum 1).
  function automatic int unsigned cnt_width(input int unsigned debounce);
    int unsigned w;
    w = $clog2(debounce + 1);
    if (w < 1) begin
      w = 1;
    end
    return w;
  endfunction

endpackage

// File: rtl/pio_debounce_bit.sv
// One input bit of the PIO: 2-flop synchronizer followed by an optional debounce filter.
// Ports:
//   clk     system clock
//   reset   synchronous active-high reset (clears sync chain, counter and filtered value)
//   din_i   asynchronous input pin
//   filt_o  synchronized, debounced value
// With DEBOUNCE > 0 the synchronized value must differ from filt for DEBOUNCE cycles while the
// counter climbs to DEBOUNCE; on the following cycle filt takes the new value. Pin-to-filt latency
// is therefore 2 + DEBOUNCE + 1 clocks.
module pio_debounce_bit
  import cpen391_pio_pkg::*;
#(
  parameter int unsigned DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din_i,
  output logic filt_o
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic filt_q, filt_d;

  always_comb begin
    meta_d = din_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      filt_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      filt_q <= filt_d;
    end
  end

  if (DEBOUNCE == 0) begin : g_bypass
    always_comb begin
      filt_d = sync_q;
    end
  end else begin : g_filter
    localparam int unsigned CntW = cnt_width(DEBOUNCE);
    localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync_q != filt_q) begin
        if (cnt_q == CntMax) begin
          filt_d = sync_q;
          cnt_d  = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_d;
      end
    end
  end

  assign filt_o = filt_q;

endmodule

// File: rtl/cpen391_computer_pio_wifi_status.sv
// Avalon-MM input PIO for the Wi-Fi module status lines (ready, connected, data-pending).
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   address      word address: 0 data, 1 reserved, 2 irq_mask, 3 edgecapture (W1C)
//   chipselect   slave select; write strobe is chipselect & ~write_n
//   write_n      active-low write strobe
//   writedata    write data
//   readdata     registered read data, one-cycle read latency, no read side effects
//   in_port      asynchronous status lines
//   irq          level interrupt: |(edgecapture & irq_mask)
module cpen391_computer_pio_wifi_status
  import cpen391_pio_pkg::*;
#(
  parameter int unsigned WIDTH          = 3,
  parameter int unsigned EDGE_TYPE      = 0,
  parameter int unsigned DEBOUNCE       = 4,
  parameter int unsigned IRQ_MASK_RESET = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [31:0] MaskRst = 32'(IRQ_MASK_RESET);

  logic [WIDTH-1:0] filt;
  logic [WIDTH-1:0] filt_dly_q, filt_dly_d;
  logic [WIDTH-1:0] edge_hit;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             wr_en;

  // Only the low WIDTH bits of writedata are meaningful.
  logic unused_writedata;
  assign unused_writedata = ^writedata;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    pio_debounce_bit #(
      .DEBOUNCE(DEBOUNCE)
    ) u_debounce (
      .clk   (clk),
      .reset (reset),
      .din_i (in_port[i]),
      .filt_o(filt[i])
    );
  end

  assign wr_en = chipselect & ~write_n;

  always_comb begin
    filt_dly_d = filt;
    if (EDGE_TYPE == EDGE_RISE) begin
      edge_hit = filt & ~filt_dly_q;
    end else if (EDGE_TYPE == EDGE_FALL) begin
      edge_hit = ~filt & filt_dly_q;
    end else begin
      edge_hit = filt ^ filt_dly_q;
    end
  end

  always_comb begin
    mask_d = mask_q;
    cap_d  = cap_q;
    if (wr_en && (address == ADDR_MASK)) begin
      mask_d = writedata[WIDTH-1:0];
    end
    if (wr_en && (address == ADDR_EDGE)) begin
      cap_d = cap_q & ~writedata[WIDTH-1:0];
    end
    // Applied after the clear so a coincident edge keeps its bit set.
    cap_d = cap_d | edge_hit;
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_DATA: readdata_d[WIDTH-1:0] = filt;
      ADDR_MASK: readdata_d[WIDTH-1:0] = mask_q;
      ADDR_EDGE: readdata_d[WIDTH-1:0] = cap_q;
      default:   readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_dly_q <= '0;
      cap_q      <= '0;
      mask_q     <= MaskRst[WIDTH-1:0];
      readdata_q <= '0;
    end else begin
      filt_dly_q <= filt_dly_d;
      cap_q      <= cap_d;
      mask_q     <= mask_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = |(cap_q & mask_q);

endmodule

// File: tb/tb_cpen391_computer_pio_wifi_status.sv
// Scoreboard bench: stimulus pushes expected read data / irq levels into queues, a monitor on the
// falling edge pops and compares. dut0 captures rising edges, dut1 captures falling edges.
module tb_cpen391_computer_pio_wifi_status;

  typedef struct {
    string       name;
    logic [31:0] exp;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic        cs0, cs1;
  logic [2:0]  in0, in1;
  logic [31:0] rd0, rd1;
  logic        irq0, irq1;

  logic rd_strobe = 1'b0;
  logic rd_sel = 1'b0;
  logic rd_vld = 1'b0;
  logic rd_vld_sel = 1'b0;
  logic irq_strobe = 1'b0;
  logic irq_sel = 1'b0;

  exp_t rd_q[$];
  exp_t irq_q[$];
  exp_t mon_e;
  logic [31:0] mon_act;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cpen391_computer_pio_wifi_status #(
    .WIDTH(3), .EDGE_TYPE(0), .DEBOUNCE(4), .IRQ_MASK_RESET(0)
  ) u_dut0 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs0), .write_n(write_n),
    .writedata(writedata), .readdata(rd0), .in_port(in0), .irq(irq0)
  );

  cpen391_computer_pio_wifi_status #(
    .WIDTH(3), .EDGE_TYPE(1), .DEBOUNCE(4), .IRQ_MASK_RESET(0)
  ) u_dut1 (
    .clk(clk), .reset(reset), .address(address), .chipselect(cs1), .write_n(write_n),
    .writedata(writedata), .readdata(rd1), .in_port(in1), .irq(irq1)
  );

  // Read data is presented the cycle after the address.
  always @(posedge clk) begin
    rd_vld     <= rd_strobe;
    rd_vld_sel <= rd_sel;
  end

  always @(negedge clk) begin
    if (rd_vld) begin
      mon_act = rd_vld_sel ? rd1 : rd0;
      checks++;
      if (rd_q.size() == 0) begin
        failures++;
        $display("FAIL rd_underflow: readdata=0x%08h with no expected entry", mon_act);
      end else begin
        mon_e = rd_q.pop_front();
        if (mon_act !== mon_e.exp) begin
          failures++;
          $display("FAIL %s: readdata=0x%08h expected=0x%08h", mon_e.name, mon_act, mon_e.exp);
        end
      end
    end
    if (irq_strobe) begin
      mon_act = {31'b0, (irq_sel ? irq1 : irq0)};
      checks++;
      if (irq_q.size() == 0) begin
        failures++;
        $display("FAIL irq_underflow: irq=%0d with no expected entry", mon_act[0]);
      end else begin
        mon_e = irq_q.pop_front();
        if (mon_act !== mon_e.exp) begin
          failures++;
          $display("FAIL %s: irq=%0d expected=%0d", mon_e.name, mon_act[0], mon_e.exp[0]);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) tick();
  endtask

  task automatic rd(input logic dut, input logic [1:0] addr, input logic [31:0] exp,
                    input string name);
    exp_t e;
    e.name = name;
    e.exp  = exp;
    rd_q.push_back(e);
    address   = addr;
    rd_sel    = dut;
    rd_strobe = 1'b1;
    tick();
    rd_strobe = 1'b0;
  endtask

  task automatic wr(input logic dut, input logic [1:0] addr, input logic [31:0] data);
    address   = addr;
    writedata = data;
    write_n   = 1'b0;
    cs0       = ~dut;
    cs1       = dut;
    tick();
    write_n = 1'b1;
    cs0     = 1'b0;
    cs1     = 1'b0;
  endtask

  task automatic chk_irq(input logic dut, input logic exp, input string name);
    exp_t e;
    e.name = name;
    e.exp  = {31'b0, exp};
    irq_q.push_back(e);
    irq_sel    = dut;
    irq_strobe = 1'b1;
    tick();
    irq_strobe = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    reset     = 1'b1;
    address   = 2'd0;
    write_n   = 1'b1;
    writedata = '0;
    cs0       = 1'b0;
    cs1       = 1'b0;
    in0       = 3'b000;
    in1       = 3'b000;
    wait_cycles(3);
    reset = 1'b0;

    // Reset state
    rd(0, 2'd0, 32'h0, "rst_data");
    rd(0, 2'd2, 32'h0, "rst_mask");
    rd(0, 2'd3, 32'h0, "rst_edge");
    rd(0, 2'd1, 32'h0, "rst_rsvd");
    chk_irq(0, 1'b0, "rst_irq");

    // Rising edge on bit0: filt changes exactly 7 clocks after the first sampling edge
    in0 = 3'b001;
    wait_cycles(6);
    rd(0, 2'd0, 32'h0, "lat_before_7");
    rd(0, 2'd0, 32'h1, "lat_at_7");
    rd(0, 2'd3, 32'h1, "edge_rise_bit0");
    chk_irq(0, 1'b0, "irq_unmasked");
    wr(0, 2'd2, 32'hFFFF_FFFF);
    rd(0, 2'd2, 32'h7, "mask_upper_zero");
    wr(0, 2'd2, 32'h1);
    chk_irq(0, 1'b1, "irq_masked");
    wr(0, 2'd1, 32'hFFFF_FFFF);
    rd(0, 2'd1, 32'h0, "rsvd_write_ignored");

    // Clearing the mask drops irq straight away
    wr(0, 2'd2, 32'h2);
    chk_irq(0, 1'b0, "irq_mask_clear");

    // 3-cycle glitch on bit1 must be filtered out
    in0 = 3'b011;
    wait_cycles(3);
    in0 = 3'b001;
    wait_cycles(10);
    rd(0, 2'd0, 32'h1, "glitch_data");
    rd(0, 2'd3, 32'h1, "glitch_edge");
    chk_irq(0, 1'b0, "glitch_irq");
    wr(0, 2'd2, 32'h1);

    // Partial W1C leaves other bits alone
    in0 = 3'b101;
    wait_cycles(10);
    rd(0, 2'd3, 32'h5, "edge_0x5");
    wr(0, 2'd3, 32'h4);
    rd(0, 2'd3, 32'h1, "w1c_partial");
    chk_irq(0, 1'b1, "w1c_partial_irq");
    wr(0, 2'd3, 32'h1);
    chk_irq(0, 1'b0, "w1c_irq_off");
    rd(0, 2'd3, 32'h0, "w1c_all_clear");

    // W1C of bit2 lands on the same edge that captures a new rise on bit2
    in0 = 3'b001;
    wait_cycles(10);
    wr(0, 2'd2, 32'h4);
    in0 = 3'b101;
    wait_cycles(7);
    wr(0, 2'd3, 32'h4);
    rd(0, 2'd3, 32'h4, "w1c_vs_edge");
    chk_irq(0, 1'b1, "w1c_vs_edge_irq");

    // Falling-edge instance
    in1 = 3'b100;
    wait_cycles(12);
    rd(1, 2'd3, 32'h0, "fall_rise_ignored");
    rd(1, 2'd0, 32'h4, "fall_data_high");
    in1 = 3'b000;
    wait_cycles(12);
    rd(1, 2'd3, 32'h4, "fall_capture");

    // Reset in the middle of a debounce run
    in1 = 3'b100;
    wait_cycles(4);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    rd(1, 2'd0, 32'h0, "rst_mid_data");
    rd(1, 2'd3, 32'h0, "rst_mid_edge");
    rd(1, 2'd2, 32'h0, "rst_mid_mask");
    wait_cycles(3);
    rd(1, 2'd0, 32'h0, "rst_mid_partial_discarded");
    rd(1, 2'd0, 32'h4, "rst_mid_refilter");
    wait_cycles(4);
    rd(1, 2'd3, 32'h0, "rst_mid_no_capture");

    // dut0 inputs were high through reset, so both rises are captured again
    rd(0, 2'd3, 32'h5, "high_at_release");
    rd(0, 2'd2, 32'h0, "mask_after_reset");
    chk_irq(0, 1'b0, "irq_after_reset");

    wait_cycles(3);
    if (rd_q.size() != 0 || irq_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: rd_left=%0d irq_left=%0d expected 0",
               rd_q.size(), irq_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpen391_computer_pio_wifi_status.md
Name: cpen391_computer_pio_wifi_status

Overview:
- Avalon-MM slave input PIO; the read-side counterpart of the existing output PIOs that drive the Wi-Fi module's control pins.
- Samples asynchronous status lines from the Wi-Fi module (ready, connected, data-pending) through a synchronizer and an optional per-bit debounce filter.
- Latches selected edges into a write-1-to-clear capture register and raises a level interrupt to the HPS.
- Sits on the lightweight HPS-to-FPGA bridge alongside the other PIOs.

Parameters:
- WIDTH, 3, number of input bits (1..32).
- EDGE_TYPE, 0, capture edge: 0 rising, 1 falling, 2 any.
- DEBOUNCE, 4, consecutive stable cycles required before the filtered value changes; 0 bypasses the filter.
- IRQ_MASK_RESET, 0, reset value of the interrupt mask register (WIDTH bits).

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- address  in  2  word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe.
- writedata  in  32  write data.
- readdata  out  32  read data, one-cycle read latency.
- in_port  in  WIDTH  asynchronous status lines from the Wi-Fi module.
- irq  out  1  level interrupt, active high.

Behaviour:
- Reset: one clock; reset is synchronous and active-high. Reset loads the following values:
  - synchronizer flops 0, filtered value 0, debounce counters 0;
  - edgecapture 0, irq_mask IRQ_MASK_RESET;
  - readdata 0, irq 0.
- Synchronizer: 2 flops per bit. sync = second stage.
- Debounce, when DEBOUNCE > 0, per bit:
  - Counter width is clog2(DEBOUNCE+1).
  - If sync != filt, the counter increments. When it reaches DEBOUNCE, filt <= sync and the counter clears, both in the same cycle.
  - If sync == filt, the counter clears.
  - A glitch shorter than DEBOUNCE cycles never reaches filt.
- DEBOUNCE = 0: filt <= sync every cycle (one register stage).
- Total latency, pin to filt:
  - 2 sync cycles + DEBOUNCE cycles + 1 filt register cycle.
  - DEBOUNCE = 4 gives 7 clocks from the first sampling edge to filt change.
- Edge detect:
  - filt_d = filt delayed one cycle.
  - rise = filt & ~filt_d; fall = ~filt & filt_d; EDGE_TYPE selects rise, fall, or rise|fall.
  - An edge sets its edgecapture bit on the cycle after filt changes.
- Register map (word addresses):
  - 0 data: read returns filt zero-extended to 32 bits; writes ignored.
  - 1 reserved: reads 0; writes ignored.
  - 2 irq_mask: read/write, bits [WIDTH-1:0]; upper bits read 0.
  - 3 edgecapture: read returns captured bits. A write clears each bit where writedata[i] = 1 (W1C); bits with writedata 0 are untouched.
- Write qualifier: chipselect & ~write_n.
- Read path:
  - readdata is registered every cycle from an address mux; the value is valid the cycle after address is presented (Avalon readLatency = 1).
  - No read side effects.
- Simultaneous W1C clear and new edge on the same bit in the same cycle: the edge wins and the bit stays 1.
- irq = |(edgecapture & irq_mask), computed combinationally from registers with no extra flop.
  - irq deasserts the cycle after a W1C write clears the last masked bit.
  - irq also deasserts immediately when the mask is cleared.
- Mask changes do not affect capture: edges latch regardless of mask.
- Input already high at reset release: filt starts at 0, so a rising edge is captured once filtering completes. Software clears edgecapture after init. This is intentional and documented for the driver.
- Reset mid-debounce: counters and filt return to 0, and any partial count is discarded.

Decomposition:
- Shared package cpen391_pio_pkg:
  - address localparams ADDR_DATA = 0, ADDR_MASK = 2, ADDR_EDGE = 3;
  - EDGE_RISE / EDGE_FALL / EDGE_ANY encodings.
- One natural sub-module, pio_debounce_bit (sync chain + counter + filt for one bit), instantiated WIDTH times via generate. Edge/capture/register/irq logic stays in the top module.

Test Plan:
- Reset, then read addr 0/2/3 -> readdata 0, 0 (IRQ_MASK_RESET = 0), 0 one cycle after each address; irq = 0.
- in_port[0] 0->1 held 20 cycles, DEBOUNCE = 4 -> data bit0 = 1 exactly 7 clocks after the first sampling edge; edgecapture = 0x1; with mask 0x1 written, irq = 1.
- in_port[1] pulse of 3 cycles, DEBOUNCE = 4 -> filt, data, and edgecapture unchanged (0); irq stays 0.
- edgecapture = 0x5, write 0x4 to addr 3 -> edgecapture = 0x1; with mask 0x1, irq stays 1. Write 0x1 -> edgecapture 0, irq 0 the next cycle.
- W1C of bit2 on the same cycle a new rising edge sets bit2 -> edgecapture bit2 = 1 and irq stays asserted when masked.
- EDGE_TYPE = 1, in_port[2] 1->0 -> bit2 captured; 0->1 -> not captured. Assert reset mid-debounce -> all registers 0, no capture.
